// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution search/fetch and MAC stages.
// Derived sizes follow from the kernel/image geometry below.
package conv_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int weight_width  = 2;
    localparam int weight_height = 2;
    localparam int img_width     = 4;
    localparam int img_height    = 4;
    localparam int padding       = 0;
    localparam int stride        = 1;
    localparam int bitwidth      = 3;

    localparam int result_width  = (img_width - weight_width + 2 * padding) / stride + 1;
    localparam int result_height = (img_height - weight_height + 2 * padding) / stride + 1;
    localparam int taps          = weight_width * weight_height;
    localparam int windows       = result_width * result_height;
    localparam int prod_width    = 2 * bitwidth;
    localparam int acc_width     = 2 * bitwidth + clog2(taps);

    // Counter widths never collapse to zero even for a 1x1 kernel or a single window.
    localparam int tap_cnt_width = (taps > 1) ? clog2(taps) : 1;
    localparam int win_cnt_width = (windows > 1) ? clog2(windows) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/conv_mul_reg.sv
// Stage 1 of the window MAC: registered signed pixel*weight product with its tap tags.
// clear drops the in-flight product so an aborted convolution leaves nothing behind.
module conv_mul_reg
    import conv_pkg::*;
(
    input  logic                  clk_en,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [bitwidth-1:0]   pix,
    input  logic [bitwidth-1:0]   wgt,
    input  logic                  in_last,
    input  logic [3:0]            in_l,
    input  logic [3:0]            in_c,
    output logic                  prod_valid,
    output logic [prod_width-1:0] prod,
    output logic                  prod_last,
    output logic [3:0]            prod_l,
    output logic [3:0]            prod_c
);

    logic signed [prod_width-1:0] pix_ext;
    logic signed [prod_width-1:0] wgt_ext;

    // Sign-extend to the full product width; the truncated product is exact in two's complement.
    assign pix_ext = {{(prod_width - bitwidth){pix[bitwidth-1]}}, pix};
    assign wgt_ext = {{(prod_width - bitwidth){wgt[bitwidth-1]}}, wgt};

    always_ff @(posedge clk_en or posedge rst) begin
        if (rst) begin
            prod_valid <= 1'b0;
            prod       <= '0;
            prod_last  <= 1'b0;
            prod_l     <= '0;
            prod_c     <= '0;
        end else if (clear) begin
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else begin
            prod_valid <= in_valid;
            if (in_valid) begin
                prod      <= pix_ext * wgt_ext;
                prod_last <= in_last;
                prod_l    <= in_l;
                prod_c    <= in_c;
            end
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// Window multiply-accumulate: sums taps per kernel window, emits one tagged result per window
// and flags the end of the convolution once every window result has been issued.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int relu_enable = 0
) (
    input  logic                 clk_en,
    input  logic                 rst,
    input  logic                 conv_on,
    input  logic                 tap_valid,
    input  logic [bitwidth-1:0]  pix_data,
    input  logic [bitwidth-1:0]  wgt_data,
    input  logic                 win_last,
    input  logic [3:0]           rlt_l,
    input  logic [3:0]           rlt_c,
    output logic                 res_valid,
    output logic [acc_width-1:0] res_data,
    output logic [3:0]           res_l,
    output logic [3:0]           res_c,
    output logic                 busy,
    output logic                 conv_done,
    output logic                 tap_err
);

    conv_state_t state_reg, state_next;

    logic [tap_cnt_width-1:0] tap_cnt_reg;
    logic [win_cnt_width-1:0] feed_win_reg;
    logic [win_cnt_width-1:0] win_cnt_reg;
    logic                     feed_done_reg;
    logic [acc_width-1:0]     acc_reg;

    logic                     accept;
    logic                     tap_last;
    logic                     s1_valid;
    logic [prod_width-1:0]    s1_prod;
    logic                     s1_last;
    logic [3:0]               s1_l;
    logic [3:0]               s1_c;
    logic [acc_width-1:0]     prod_ext;
    logic [acc_width-1:0]     sum;
    logic                     final_win;

    // Taps stop being accepted once the last window has been fully fetched.
    assign accept    = (state_reg == ACC) && conv_on && tap_valid && !feed_done_reg;
    assign tap_last  = (tap_cnt_reg == tap_cnt_width'(taps - 1));
    assign prod_ext  = {{(acc_width - prod_width){s1_prod[prod_width-1]}}, s1_prod};
    assign sum       = acc_reg + prod_ext;
    assign final_win = (win_cnt_reg == win_cnt_width'(windows - 1));

    conv_mul_reg u_mul (
        .clk_en     (clk_en),
        .rst        (rst),
        .clear      (!conv_on),
        .in_valid   (accept),
        .pix        (pix_data),
        .wgt        (wgt_data),
        .in_last    (tap_last),
        .in_l       (rlt_l),
        .in_c       (rlt_c),
        .prod_valid (s1_valid),
        .prod       (s1_prod),
        .prod_last  (s1_last),
        .prod_l     (s1_l),
        .prod_c     (s1_c)
    );

    always_ff @(posedge clk_en or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        conv_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (conv_on) state_next = ACC;
            end
            ACC: begin
                busy = 1'b1;
                if (s1_valid && s1_last && final_win) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                conv_done = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (!conv_on) state_next = IDLE;
    end

    always_ff @(posedge clk_en or posedge rst) begin
        if (rst) begin
            tap_cnt_reg   <= '0;
            feed_win_reg  <= '0;
            win_cnt_reg   <= '0;
            feed_done_reg <= 1'b0;
            acc_reg       <= '0;
            tap_err       <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_l         <= '0;
            res_c         <= '0;
        end else if (!conv_on) begin
            tap_cnt_reg   <= '0;
            feed_win_reg  <= '0;
            win_cnt_reg   <= '0;
            feed_done_reg <= 1'b0;
            acc_reg       <= '0;
            tap_err       <= 1'b0;
            res_valid     <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (accept) begin
                tap_cnt_reg <= tap_last ? '0 : tap_cnt_reg + 1'b1;
                if (win_last != tap_last) tap_err <= 1'b1;
                if (tap_last) begin
                    feed_win_reg <= feed_win_reg + 1'b1;
                    if (feed_win_reg == win_cnt_width'(windows - 1)) feed_done_reg <= 1'b1;
                end
            end
            // A last-flagged product closes the window and restarts the sum in the same cycle.
            if ((state_reg == ACC) && s1_valid) begin
                if (s1_last) begin
                    res_valid   <= 1'b1;
                    res_data    <= ((relu_enable != 0) && sum[acc_width-1]) ? '0 : sum;
                    res_l       <= s1_l;
                    res_c       <= s1_c;
                    acc_reg     <= '0;
                    win_cnt_reg <= win_cnt_reg + 1'b1;
                end else begin
                    acc_reg <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: a plain and a ReLU instance share stimulus; results are
// scoreboarded with data, coordinates and the exact cycle they must appear.
module tb_conv_window_mac;
    import conv_pkg::*;

    logic                 clk_en = 1'b0;
    logic                 rst;
    logic                 conv_on;
    logic                 tap_valid;
    logic [bitwidth-1:0]  pix_data;
    logic [bitwidth-1:0]  wgt_data;
    logic                 win_last;
    logic [3:0]           rlt_l;
    logic [3:0]           rlt_c;

    logic                 a_res_valid, b_res_valid;
    logic [acc_width-1:0] a_res_data, b_res_data;
    logic [3:0]           a_res_l, a_res_c, b_res_l, b_res_c;
    logic                 a_busy, a_conv_done, a_tap_err;
    logic                 b_busy, b_conv_done, b_tap_err;

    typedef struct {
        int data;
        int l;
        int c;
        int t;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    always #5 clk_en = ~clk_en;
    always @(posedge clk_en) cyc <= cyc + 1;

    conv_window_mac #(.relu_enable(0)) dut_a (
        .clk_en(clk_en), .rst(rst), .conv_on(conv_on), .tap_valid(tap_valid),
        .pix_data(pix_data), .wgt_data(wgt_data), .win_last(win_last),
        .rlt_l(rlt_l), .rlt_c(rlt_c), .res_valid(a_res_valid), .res_data(a_res_data),
        .res_l(a_res_l), .res_c(a_res_c), .busy(a_busy), .conv_done(a_conv_done),
        .tap_err(a_tap_err)
    );

    conv_window_mac #(.relu_enable(1)) dut_b (
        .clk_en(clk_en), .rst(rst), .conv_on(conv_on), .tap_valid(tap_valid),
        .pix_data(pix_data), .wgt_data(wgt_data), .win_last(win_last),
        .rlt_l(rlt_l), .rlt_c(rlt_c), .res_valid(b_res_valid), .res_data(b_res_data),
        .res_l(b_res_l), .res_c(b_res_c), .busy(b_busy), .conv_done(b_conv_done),
        .tap_err(b_tap_err)
    );

    // Scoreboard monitor: every res_valid must match the oldest outstanding expectation.
    always @(negedge clk_en) begin
        exp_t e;
        if (a_res_valid) begin
            checks++;
            if (q_a.size() == 0) begin
                $display("FAIL res_a unexpected: data=%0d l=%0d c=%0d cyc=%0d, no result expected",
                         $signed(a_res_data), a_res_l, a_res_c, cyc);
            end else begin
                e = q_a.pop_front();
                if (int'($signed(a_res_data)) != e.data || int'(a_res_l) != e.l ||
                    int'(a_res_c) != e.c || cyc != e.t)
                    $display("FAIL res_a: got data=%0d l=%0d c=%0d cyc=%0d, want data=%0d l=%0d c=%0d cyc=%0d",
                             $signed(a_res_data), a_res_l, a_res_c, cyc, e.data, e.l, e.c, e.t);
                else
                    passed++;
            end
        end
        if (b_res_valid) begin
            checks++;
            if (q_b.size() == 0) begin
                $display("FAIL res_b unexpected: data=%0d l=%0d c=%0d cyc=%0d, no result expected",
                         $signed(b_res_data), b_res_l, b_res_c, cyc);
            end else begin
                e = q_b.pop_front();
                if (int'($signed(b_res_data)) != e.data || int'(b_res_l) != e.l ||
                    int'(b_res_c) != e.c || cyc != e.t)
                    $display("FAIL res_b: got data=%0d l=%0d c=%0d cyc=%0d, want data=%0d l=%0d c=%0d cyc=%0d",
                             $signed(b_res_data), b_res_l, b_res_c, cyc, e.data, e.l, e.c, e.t);
                else
                    passed++;
            end
        end
    end

    // Drives one tap for one cycle; called at a negedge, returns at the next negedge.
    task automatic drive_tap(input int p, input int w, input bit last, input int l, input int c);
        tap_valid = 1'b1;
        pix_data  = bitwidth'(p);
        wgt_data  = bitwidth'(w);
        win_last  = last;
        rlt_l     = 4'(l);
        rlt_c     = 4'(c);
        @(negedge clk_en);
        tap_valid = 1'b0;
        win_last  = 1'b0;
    endtask

    task automatic send_window(input int p[4], input int w[4], input int gap_max,
                               input int bad_tap, input int l, input int c);
        int sum;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += p[i] * w[i];
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk_en);
            if (i == 3) begin
                q_a.push_back('{sum, l, c, cyc + 2});
                q_b.push_back('{(sum < 0) ? 0 : sum, l, c, cyc + 2});
            end
            drive_tap(p[i], w[i], (i == 3) || (i == bad_tap), l, c);
        end
    endtask

    task automatic run_conv(input int p[4], input int w[4], input int gap_max, input int bad_win);
        conv_on = 1'b1;
        @(negedge clk_en);
        for (int l = 0; l < result_height; l++) begin
            for (int c = 0; c < result_width; c++) begin
                send_window(p, w, gap_max, (l * result_width + c == bad_win) ? 2 : -1, l, c);
                if (l * result_width + c == bad_win) begin
                    checks++;
                    if (a_tap_err !== 1'b1)
                        $display("FAIL tap_err_set: got %b, want 1", a_tap_err);
                    else
                        passed++;
                end
            end
        end
        @(negedge clk_en);
        checks++;
        if (a_busy !== 1'b1 || a_conv_done !== 1'b0)
            $display("FAIL drain: got busy=%b done=%b, want busy=1 done=0", a_busy, a_conv_done);
        else
            passed++;
        @(negedge clk_en);
        checks++;
        if (a_busy !== 1'b0 || a_conv_done !== 1'b1 || b_conv_done !== 1'b1 ||
            a_tap_err !== (bad_win >= 0))
            $display("FAIL done: got busy=%b done=%b/%b err=%b, want busy=0 done=1/1 err=%b",
                     a_busy, a_conv_done, b_conv_done, a_tap_err, bad_win >= 0);
        else
            passed++;
        // A tap arriving in DONE must be ignored.
        drive_tap(1, 1, 1'b1, 0, 0);
        repeat (3) @(negedge clk_en);
        checks++;
        if (a_conv_done !== 1'b1)
            $display("FAIL done_hold: got %b, want 1", a_conv_done);
        else
            passed++;
        conv_on = 1'b0;
        @(negedge clk_en);
        checks++;
        if (a_conv_done !== 1'b0 || a_tap_err !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL conv_off: got done=%b err=%b busy=%b, want 0 0 0",
                     a_conv_done, a_tap_err, a_busy);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; conv_on = 1'b0; tap_valid = 1'b0; win_last = 1'b0;
        pix_data = '0; wgt_data = '0; rlt_l = '0; rlt_c = '0;
        repeat (3) @(negedge clk_en);
        checks++;
        if ({a_res_valid, a_res_data, a_res_l, a_res_c, a_busy, a_conv_done, a_tap_err} !== '0)
            $display("FAIL reset: got valid=%b data=%0d l=%0d c=%0d busy=%b done=%b err=%b, want all 0",
                     a_res_valid, a_res_data, a_res_l, a_res_c, a_busy, a_conv_done, a_tap_err);
        else
            passed++;
        rst = 1'b0;
        @(negedge clk_en);
    endtask

    task automatic test_ones();
        run_conv('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, -1);
    endtask

    task automatic test_signed();
        run_conv('{-4, -4, -4, -4}, '{-4, -4, -4, -4}, 0, -1);
        run_conv('{-4, -4, -4, -4}, '{3, 3, 3, 3}, 0, -1);
    endtask

    task automatic test_gaps();
        run_conv('{1, 2, 3, 0}, '{1, 1, 1, 1}, 3, -1);
    endtask

    task automatic test_tap_err();
        run_conv('{1, -2, 3, 2}, '{2, 1, -1, 3}, 1, 4);
    endtask

    task automatic test_abort();
        conv_on = 1'b1;
        @(negedge clk_en);
        for (int k = 0; k < 5; k++)
            send_window('{1, 1, 1, 1}, '{2, 2, 2, 2}, 0, -1, k / result_width, k % result_width);
        drive_tap(3, 3, 1'b0, 1, 2);
        drive_tap(3, 3, 1'b0, 1, 2);
        conv_on = 1'b0;
        @(negedge clk_en);
        checks++;
        if (a_busy !== 1'b0 || a_res_valid !== 1'b0)
            $display("FAIL abort: got busy=%b valid=%b, want 0 0", a_busy, a_res_valid);
        else
            passed++;
        repeat (4) @(negedge clk_en);
        run_conv('{1, 2, 3, 1}, '{1, 1, 1, 2}, 0, -1);
    endtask

    task automatic test_async_reset();
        conv_on = 1'b1;
        @(negedge clk_en);
        send_window('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, -1, 0, 0);
        drive_tap(1, 1, 1'b0, 0, 1);
        @(posedge clk_en);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_res_valid, a_res_data, a_res_l, a_res_c, a_busy, a_conv_done, a_tap_err,
             b_res_valid, b_busy} !== '0)
            $display("FAIL async_rst: got valid=%b data=%0d busy=%b done=%b, want all 0",
                     a_res_valid, a_res_data, a_busy, a_conv_done);
        else
            passed++;
        // The in-flight window result was cancelled by the reset.
        q_a.delete();
        q_b.delete();
        conv_on = 1'b0;
        @(negedge clk_en);
        rst = 1'b0;
        repeat (4) @(negedge clk_en);
        checks++;
        if (a_busy !== 1'b0 || a_conv_done !== 1'b0)
            $display("FAIL post_rst: got busy=%b done=%b, want 0 0", a_busy, a_conv_done);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_signed();
        test_gaps();
        test_abort();
        test_tap_err();
        test_async_reset();
        repeat (3) @(negedge clk_en);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0)
            $display("FAIL missing_results: got %0d/%0d outstanding, want 0/0", q_a.size(), q_b.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
